calc_alu_seq: RTL and testbench

Parametrised, clocked successor to the calculator's arithmetic unit. It performs signed add, subtract, multiply and divide on two W-bit operands under a start/busy/done handshake. Multiply and divide are iterative, one bit per cycle, to bound area. The calculator's control FSM drives it when the user presses equals; the display path consumes `answer`.

---
 rtl/calc_pkg.sv | 17 +
 rtl/calc_alu_seq_if.sv | 27 ++
 rtl/calc_muldiv_iter.sv | 68 ++++++
 rtl/calc_alu_seq.sv | 155 +++++++++++++++
 tb/tb_calc_alu_seq.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared opcodes and FSM state encoding for the sequential
// calculator ALU.
package calc_pkg;

    localparam logic [3:0] OP_ADD = 4'b1111;
    localparam logic [3:0] OP_SUB = 4'b1110;
    localparam logic [3:0] OP_MUL = 4'b1101;
    localparam logic [3:0] OP_DIV = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

endpackage

// File: rtl/calc_alu_seq_if.sv
// Start/busy/done request bus between the control FSM and
// the sequential ALU.
interface calc_alu_seq_if #(
    parameter int W  = 11,
    parameter int RW = 2*W-1
);
    logic                 start;
    logic [3:0]           operator;
    logic signed [W-1:0]  operandA;
    logic signed [W-1:0]  operandB;
    logic                 busy;
    logic                 done;
    logic signed [RW-1:0] answer;
    logic signed [W-1:0]  remainder;
    logic                 error;
    logic                 overflow;

    modport master (
        output start, operator, operandA, operandB,
        input  busy, done, answer, remainder, error, overflow
    );

    modport slave (
        input  start, operator, operandA, operandB,
        output busy, done, answer, remainder, error, overflow
    );
endinterface

// File: rtl/calc_muldiv_iter.sv
// Unsigned one-bit-per-cycle multiplier / restoring divider
// working on operand magnitudes, with its iteration counter.
module calc_muldiv_iter #(
    parameter int W = 11
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           mode,
    input  logic           step,
    input  logic [W-1:0]   a_mag,
    input  logic [W-1:0]   b_mag,
    output logic [2*W-1:0] prod,
    output logic [W-1:0]   quot,
    output logic [W-1:0]   rem,
    output logic           last
);
    localparam int CW = $clog2(W);

    logic           mode_q;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] mc;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic [CW-1:0]  cnt;
    logic [W:0]     sh;
    logic [W:0]     dif;

    // Partial remainder shifted left with the next dividend bit.
    assign sh  = {r, q[W-1]};
    assign dif = sh - {1'b0, mc[W-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
            acc    <= '0;
            mc     <= '0;
            q      <= '0;
            r      <= '0;
            cnt    <= '0;
        end else if (load) begin
            mode_q <= mode;
            acc    <= '0;
            mc     <= {{W{1'b0}}, mode ? b_mag : a_mag};
            q      <= mode ? a_mag : b_mag;
            r      <= '0;
            cnt    <= CW'(W-1);
        end else if (step) begin
            cnt <= cnt - 1'b1;
            if (!mode_q) begin
                if (q[0]) acc <= acc + mc;
                mc <= mc << 1;
                q  <= q >> 1;
            end else if (!dif[W]) begin
                r <= dif[W-1:0];
                q <= {q[W-2:0], 1'b1};
            end else begin
                r <= sh[W-1:0];
                q <= {q[W-2:0], 1'b0};
            end
        end
    end

    assign prod = acc;
    assign quot = q;
    assign rem  = r;
    assign last = (cnt == '0);
endmodule

// File: rtl/calc_alu_seq.sv
// Clocked signed add/sub/mul/div unit with start/busy/done
// handshake; mul/div iterate one bit per cycle.
module calc_alu_seq
    import calc_pkg::*;
#(
    parameter int W  = 11,
    parameter int RW = 2*W-1
) (
    input logic           clk,
    input logic           rst_n,
    calc_alu_seq_if.slave bus
);
    state_t state, state_n;

    logic [3:0]           op_q;
    logic signed [W-1:0]  a_q, b_q;
    logic signed [RW-1:0] res_q, ans_o, fix_res, d_ans;
    logic signed [W-1:0]  rem_q, rem_o, fix_rem, d_rem;
    logic                 ovf_q, ovf_o, err_o, done_q;
    logic                 fix_ovf, d_err, d_ovf;
    logic                 load, step, last, neg, is_md;
    logic [2*W-1:0]       prod, pfull;
    logic [W-1:0]         quot, rem;
    logic [RW-1:0]        qx;

    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? -x : x;
    endfunction

    calc_muldiv_iter #(.W(W)) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .mode  (bus.operator == OP_DIV),
        .step  (step),
        .a_mag (mag(bus.operandA)),
        .b_mag (mag(bus.operandB)),
        .prod  (prod),
        .quot  (quot),
        .rem   (rem),
        .last  (last)
    );

    // Divide-by-zero skips the iterative path entirely.
    assign is_md = (bus.operator == OP_MUL) ||
                   (bus.operator == OP_DIV && bus.operandB != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state)
            S_IDLE: if (bus.start) begin
                if (is_md) begin
                    load    = 1'b1;
                    state_n = S_RUN;
                end else begin
                    state_n = S_DONE;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (last) state_n = S_FIX;
            end
            S_FIX:   state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign neg   = a_q[W-1] ^ b_q[W-1];
    assign pfull = neg ? -prod : prod;
    assign qx    = {{(RW-W){1'b0}}, quot};

    always_comb begin
        fix_res = '0;
        fix_rem = '0;
        fix_ovf = 1'b0;
        if (op_q == OP_MUL) begin
            fix_res = pfull[RW-1:0];
            fix_ovf = pfull[2*W-1] ^ pfull[2*W-2];
        end else begin
            fix_res = neg ? -qx : qx;
            fix_rem = a_q[W-1] ? -rem : rem;
        end
    end

    always_comb begin
        d_ans = '0;
        d_rem = '0;
        d_err = 1'b0;
        d_ovf = 1'b0;
        unique case (1'b1)
            op_q == OP_ADD: d_ans = RW'(a_q) + RW'(b_q);
            op_q == OP_SUB: d_ans = RW'(a_q) - RW'(b_q);
            op_q == OP_MUL: begin
                d_ans = res_q;
                d_ovf = ovf_q;
            end
            op_q == OP_DIV && b_q == '0: d_err = 1'b1;
            op_q == OP_DIV && b_q != '0: begin
                d_ans = res_q;
                d_rem = rem_q;
            end
            default: d_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            rem_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
            ans_o  <= '0;
            rem_o  <= '0;
            err_o  <= 1'b0;
            ovf_o  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == S_IDLE && bus.start) begin
                op_q <= bus.operator;
                a_q  <= bus.operandA;
                b_q  <= bus.operandB;
            end
            if (state == S_FIX) begin
                res_q <= fix_res;
                rem_q <= fix_rem;
                ovf_q <= fix_ovf;
            end
            if (state == S_DONE) begin
                done_q <= 1'b1;
                ans_o  <= d_ans;
                rem_o  <= d_rem;
                err_o  <= d_err;
                ovf_o  <= d_ovf;
            end
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_q;
    assign bus.answer    = ans_o;
    assign bus.remainder = rem_o;
    assign bus.error     = err_o;
    assign bus.overflow  = ovf_o;
endmodule

// File: tb/tb_calc_alu_seq.sv
// Bench for calc_alu_seq: directed cases, random traffic,
// and a cycle-level behavioural model compared every cycle.
module tb_calc_alu_seq;
    localparam int W  = 11;
    localparam int RW = 2*W-1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    calc_alu_seq_if #(.W(W), .RW(RW)) bus ();

    calc_alu_seq #(.W(W), .RW(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name,
                       input longint act,
                       input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Result of one operation, straight from the arithmetic rules.
    function automatic void model(
        input  logic [3:0] op,
        input  longint     a,
        input  longint     b,
        output longint     ans,
        output longint     rem,
        output bit         err,
        output bit         ovf,
        output int         lat
    );
        longint p, t, span, maxr, minr;
        span = longint'(1) <<< RW;
        maxr = (longint'(1) <<< (RW-1)) - 1;
        minr = -(longint'(1) <<< (RW-1));
        ans = 0; rem = 0; err = 0; ovf = 0; lat = 1;
        case (op)
            4'b1111: ans = a + b;
            4'b1110: ans = a - b;
            4'b1101: begin
                p   = a * b;
                lat = W + 2;
                ovf = (p > maxr) || (p < minr);
                t   = p & (span - 1);
                if (t > maxr) t = t - span;
                ans = t;
            end
            4'b1100: begin
                if (b == 0) err = 1;
                else begin
                    ans = a / b;
                    rem = a % b;
                    lat = W + 2;
                end
            end
            default: err = 1;
        endcase
    endfunction

    longint m_ans = 0, m_rem = 0, p_ans = 0, p_rem = 0;
    bit     m_err = 0, m_ovf = 0, p_err = 0, p_ovf = 0;
    bit     m_done = 0, m_busy = 0, have_op = 0, acc = 0;
    int     edge_n = 0, due = 0, p_lat = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_op = 0;
            m_done  = 0;
            m_busy  = 0;
            m_ans   = 0;
            m_rem   = 0;
            m_err   = 0;
            m_ovf   = 0;
        end else begin
            acc    = bus.start && !have_op;
            m_done = 0;
            if (have_op && edge_n == due) begin
                m_ans   = p_ans;
                m_rem   = p_rem;
                m_err   = p_err;
                m_ovf   = p_ovf;
                m_done  = 1;
                have_op = 0;
            end
            if (acc) begin
                model(bus.operator, bus.operandA, bus.operandB,
                      p_ans, p_rem, p_err, p_ovf, p_lat);
                have_op = 1;
                due     = edge_n + p_lat;
            end
            m_busy = have_op;
            edge_n++;
        end
    end

    always @(negedge clk) begin
        chk("done",      bus.done,      m_done);
        chk("busy",      bus.busy,      m_busy);
        chk("answer",    bus.answer,    m_ans);
        chk("remainder", bus.remainder, m_rem);
        chk("error",     bus.error,     m_err);
        chk("overflow",  bus.overflow,  m_ovf);
    end

    task automatic drive(input logic [3:0] op,
                         input int a, input int b);
        bus.start    = 1'b1;
        bus.operator = op;
        bus.operandA = W'(a);
        bus.operandB = W'(b);
    endtask

    task automatic run_op(input string nm,
                          input logic [3:0] op,
                          input int a, input int b,
                          input longint e_ans, input longint e_rem,
                          input bit e_err, input bit e_ovf,
                          input int e_lat);
        longint ma, mr;
        bit     me, mo, got;
        int     ml, n;
        model(op, a, b, ma, mr, me, mo, ml);
        chk({nm, "_model_ans"}, ma, e_ans);
        chk({nm, "_model_lat"}, ml, e_lat);
        @(posedge clk); #2;
        drive(op, a, b);
        @(posedge clk); #2;
        bus.start = 1'b0;
        got = 0;
        n   = 0;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (bus.done) got = 1;
        end
        chk({nm, "_seen_done"}, got, 1);
        if (got) begin
            chk({nm, "_lat"}, n - 1, e_lat);
            chk({nm, "_ans"}, bus.answer, e_ans);
            chk({nm, "_rem"}, bus.remainder, e_rem);
            chk({nm, "_err"}, bus.error, e_err);
            chk({nm, "_ovf"}, bus.overflow, e_ovf);
        end
    endtask

    initial begin
        int dones, n, r;
        bit got;
        bus.start    = 1'b0;
        bus.operator = 4'b0;
        bus.operandA = '0;
        bus.operandB = '0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_answer", bus.answer, 0);
        chk("rst_busy", bus.busy, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        run_op("add", 4'b1111, 1023, -1024, -1, 0, 0, 0, 1);
        run_op("sub", 4'b1110, -1024, 1023, -2047, 0, 0, 0, 1);
        run_op("mul", 4'b1101, -37, 25, -925, 0, 0, 0, 13);
        run_op("mulmin", 4'b1101, -1024, -1024,
               -1048576, 0, 0, 1, 13);
        run_op("div", 4'b1100, -100, 7, -14, -2, 0, 0, 13);
        run_op("divmin", 4'b1100, -1024, -1, 1024, 0, 0, 0, 13);
        run_op("div0", 4'b1100, 5, 0, 0, 0, 1, 0, 1);
        run_op("illegal", 4'b0000, 9, 3, 0, 0, 1, 0, 1);
        run_op("add_clr", 4'b1111, 3, 4, 7, 0, 0, 0, 1);

        // start held high through a mul, then a back-to-back add
        @(posedge clk); #2;
        drive(4'b1101, 123, -45);
        @(posedge clk); #2;
        drive(4'b1111, 5, 6);
        dones = 0;
        got   = 0;
        n     = 0;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (bus.done) begin
                dones++;
                got = 1;
            end
        end
        chk("pulse_done_seen", got, 1);
        chk("pulse_mul_ans", bus.answer, -5535);
        @(posedge clk); #2;
        bus.start = 1'b0;
        @(negedge clk);
        if (bus.done) dones++;
        chk("pulse_one_done", dones, 1);
        @(negedge clk);
        chk("b2b_done", bus.done, 1);
        chk("b2b_ans", bus.answer, 11);

        // reset in the middle of a divide
        @(posedge clk); #2;
        drive(4'b1100, -100, 7);
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_answer", bus.answer, 0);
        chk("abort_busy", bus.busy, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("abort_no_done", dones, 0);
        run_op("add_after_rst", 4'b1111, -7, 2, -5, 0, 0, 0, 1);

        // random traffic, start toggled regardless of busy
        repeat (2500) begin
            @(posedge clk); #2;
            r = $urandom_range(0, 9);
            bus.start = ($urandom_range(0, 2) != 0);
            case (r)
                0, 1: bus.operator = 4'b1111;
                2, 3: bus.operator = 4'b1110;
                4, 5: bus.operator = 4'b1101;
                6, 7, 9: bus.operator = 4'b1100;
                default: bus.operator = 4'($urandom_range(0, 11));
            endcase
            bus.operandA = W'($urandom);
            bus.operandB = (r == 9) ? '0 : W'($urandom);
            if ($urandom_range(0, 7) == 0)
                bus.operandA = {1'b1, {(W-1){1'b0}}};
            if ($urandom_range(0, 7) == 0)
                bus.operandB = ($urandom_range(0, 1) != 0) ?
                               {1'b1, {(W-1){1'b0}}} : '1;
        end
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
